game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
Per-round countdown timer for the math game. Counts seconds down from a two-digit BCD start value and drives one 4-bit BCD digit to each of two seven-segment decoder instances (tens, ones). Asserts a one-cycle timeout pulse when the count reaches 00, which the game controller uses to end the round. Sits directly upstream of the seven-segment decoders.

Parameters:
TICK_CYCLES, 50000000, clock cycles per one-second tick; legal range is >= 2; the bench uses 4.
START_TENS, 9, BCD tens digit loaded on start; legal range 0..9.
START_ONES, 9, BCD ones digit loaded on start; legal range 0..9.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start_i  input  1  load start value and run; level-sampled every edge; a held-high start restarts every cycle.
hold_i  input  1  pause; while high in RUN, the prescaler and digits freeze.
tens_out  output  4  BCD tens digit, to the tens decoder.
ones_out  output  4  BCD ones digit, to the ones decoder.
running_o  output  1  high while in RUN, including while held.
timeout_o  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - tens_out=START_TENS, ones_out=START_ONES.
  - running_o=0, timeout_o=0.
  - Prescaler count 0.
- Registered outputs: all outputs come from registers, with no combinational path from inputs to outputs.
- Prescaler: a counter of width ceil(log2(TICK_CYCLES)).
  - Increments once per cycle only in RUN with hold_i=0.
  - At TICK_CYCLES-1 it wraps to 0 and generates an internal tick in that same cycle.
- Decrement on tick:
  - If ones>0: ones<=ones-1.
  - Else: ones<=9, tens<=tens-1.
  - Digits never leave the range 0..9.
- States: IDLE, RUN, DONE.
- IDLE:
  - Digits hold the start value; running_o=0.
  - start_i=1: next cycle goes to RUN, reloads the digits, clears the prescaler, running_o=1.
  - Exception: if START_TENS=START_ONES=0, start_i=1 goes straight to DONE, with timeout_o=1 in the next cycle.
- RUN:
  - A tick that takes the digits from 01 to 00 enters DONE at the same edge: digits=00, running_o=0, timeout_o=1 for exactly that one cycle.
  - hold_i=1: prescaler and digits hold their values; running_o stays 1.
  - start_i=1 (restart): reloads the digits, clears the prescaler, stays in RUN. Restart has priority over a coincident tick and over hold_i.
- DONE:
  - Digits hold 00; running_o=0; timeout_o=0 after its single pulse.
  - start_i=1: same reload and transition as in IDLE.
  - hold_i is ignored.
- Latency: the first decrement is visible TICK_CYCLES cycles after the edge that samples start_i=1. Subsequent decrements occur every TICK_CYCLES cycles of un-held RUN time.
- Hold timing: holding does not reset the prescaler. After release, the partial count resumes from where it stopped.
- Reset mid-operation: rst asserted at any time forces the reset values immediately (asynchronously). No timeout_o pulse is generated.
- Timeout repetition: timeout_o never asserts twice without an intervening start.
- Full countdown duration: from start to timeout is (10*START_TENS+START_ONES)*TICK_CYCLES cycles.

Test Plan:
1. Reset then idle, TICK_CYCLES=4, START=99: release rst, hold start_i=0 for 20 cycles -> tens/ones stay 9/9, running_o=0, timeout_o=0.
2. Ones-to-tens borrow, START=12: pulse start_i -> running_o=1 next cycle; digits go 12 -> 11 -> 10 -> 09 at 4-cycle spacing.
3. Full run, START=03: pulse start_i -> digits go 03 -> 02 -> 01 -> 00, with 00 appearing 12 cycles after start is sampled; timeout_o=1 for exactly one cycle coincident with 00; running_o=0; digits stay 00 for a further 20 cycles.
4. Hold, START=05: start, wait 2 cycles, hold_i=1 for 10 cycles, release -> first decrement to 04 occurs 4 un-held cycles after start (cycle 14); no change while held.
5. Restart, START=99: start, run until 97, pulse start_i on a cycle where a tick is due -> digits 99, prescaler restarts, no decrement to 96. Then start from DONE (START=01) -> reload to 01, running_o=1.
6. Async reset mid-count, START=99: at 95, assert rst between clock edges -> digits 99 and running_o=0 immediately, before the next edge; timeout_o stays 0.

Source files
------------

// File: rtl/game_countdown_timer.sv
// Two-digit BCD seconds countdown for one game round.
// Drives the tens/ones seven-segment decoders and pulses timeout_o when the count hits 00.
module game_countdown_timer #(
   parameter int TICK_CYCLES = 50000000,
   parameter int START_TENS  = 9,
   parameter int START_ONES  = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       hold_i,
   output logic [3:0] tens_out,
   output logic [3:0] ones_out,
   output logic       running_o,
   output logic       timeout_o
);

   localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [3:0] LOAD_TENS = 4'(START_TENS);
   localparam logic [3:0] LOAD_ONES = 4'(START_ONES);
   localparam bit ZERO_START = (START_TENS == 0) && (START_ONES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic          running_q, running_d;
   logic          timeout_q, timeout_d;
   logic          tick;
   logic          last_second;

   assign tick        = (state_q == ST_RUN) && !start_i && !hold_i && (presc_q == PRESC_LAST);
   assign last_second = (tens_q == 4'd0) && (ones_q == 4'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         tens_q    <= LOAD_TENS;
         ones_q    <= LOAD_ONES;
         running_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         running_q <= running_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) state_d = ZERO_START ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (start_i)                   state_d = ST_RUN;
            else if (tick && last_second)  state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Restart wins over a coincident tick and over hold; tick already excludes both.
   always_comb begin
      presc_d = presc_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      if (start_i) begin
         presc_d = '0;
         tens_d  = LOAD_TENS;
         ones_d  = LOAD_ONES;
      end else if (state_q == ST_RUN && !hold_i) begin
         if (tick) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
               ones_d = ones_q - 4'd1;
            end else begin
               ones_d = 4'd9;
               tens_d = tens_q - 4'd1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_comb begin
      running_d = (state_d == ST_RUN);
      timeout_d = (state_d == ST_DONE) && ((state_q != ST_DONE) || start_i);
   end

   assign tens_out  = tens_q;
   assign ones_out  = ones_q;
   assign running_o = running_q;
   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed bench: six timer instances with different start values share one clock.
module tb_game_countdown_timer;

   localparam int N = 6;
   // Instance k start value: 99, 12, 03, 05, 01, 00
   localparam logic [4*N-1:0] TENS_TBL = 24'h000019;
   localparam logic [4*N-1:0] ONES_TBL = 24'h015329;

   logic           clk = 1'b0;
   logic [N-1:0]   rs;
   logic [N-1:0]   st;
   logic [N-1:0]   hd;
   logic [N-1:0]   run_w;
   logic [N-1:0]   to_w;
   logic [3:0]     tens_w [N];
   logic [3:0]     ones_w [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         game_countdown_timer #(
            .TICK_CYCLES (4),
            .START_TENS  (int'(TENS_TBL[gi*4 +: 4])),
            .START_ONES  (int'(ONES_TBL[gi*4 +: 4]))
         ) u_dut (
            .clk       (clk),
            .rst       (rs[gi]),
            .start_i   (st[gi]),
            .hold_i    (hd[gi]),
            .tens_out  (tens_w[gi]),
            .ones_out  (ones_w[gi]),
            .running_o (run_w[gi]),
            .timeout_o (to_w[gi])
         );
      end
   endgenerate

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int dig(input int k);
      return {24'd0, tens_w[k], ones_w[k]};
   endfunction

   initial begin
      int pulses;
      rs = '1;
      st = '0;
      hd = '0;
      #3;
      chk("rst_digits_99", dig(0), 'h99);
      chk("rst_digits_12", dig(1), 'h12);
      chk("rst_running", int'(run_w), 0);
      chk("rst_timeout", int'(to_w), 0);
      cyc(2);
      rs = '0;

      // 1: idle
      cyc(20);
      chk("idle_digits", dig(0), 'h99);
      chk("idle_running", int'(run_w[0]), 0);
      chk("idle_timeout", int'(to_w[0]), 0);

      // 2: borrow, START=12
      st[1] = 1'b1;
      cyc(1);
      st[1] = 1'b0;
      chk("b_running", int'(run_w[1]), 1);
      chk("b_d0", dig(1), 'h12);
      cyc(3);
      chk("b_d3", dig(1), 'h12);
      cyc(1);
      chk("b_d4", dig(1), 'h11);
      cyc(4);
      chk("b_d8", dig(1), 'h10);
      cyc(4);
      chk("b_d12", dig(1), 'h09);
      chk("b_run_still", int'(run_w[1]), 1);

      // 3: full run, START=03
      st[2] = 1'b1;
      cyc(1);
      st[2] = 1'b0;
      pulses = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc(1);
         if (to_w[2]) pulses++;
         if (i == 4) chk("f_d4", dig(2), 'h02);
         if (i == 8) chk("f_d8", dig(2), 'h01);
         if (i == 11) chk("f_d11", dig(2), 'h01);
      end
      chk("f_d12", dig(2), 'h00);
      chk("f_timeout_at_00", int'(to_w[2]), 1);
      chk("f_running_done", int'(run_w[2]), 0);
      for (int i = 0; i < 21; i++) begin
         cyc(1);
         if (to_w[2]) pulses++;
      end
      chk("f_pulse_count", pulses, 1);
      chk("f_digits_hold", dig(2), 'h00);
      hd[2] = 1'b1;
      cyc(3);
      hd[2] = 1'b0;
      chk("f_hold_ignored", dig(2), 'h00);

      // 4: hold, START=05
      st[3] = 1'b1;
      cyc(1);
      st[3] = 1'b0;
      cyc(2);
      hd[3] = 1'b1;
      cyc(10);
      chk("h_frozen", dig(3), 'h05);
      chk("h_running", int'(run_w[3]), 1);
      hd[3] = 1'b0;
      cyc(1);
      chk("h_d13", dig(3), 'h05);
      cyc(1);
      chk("h_d14", dig(3), 'h04);

      // 5: restart on a tick, START=99
      st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      cyc(8);
      chk("r_d97", dig(0), 'h97);
      cyc(3);
      st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      chk("r_reload", dig(0), 'h99);
      chk("r_running", int'(run_w[0]), 1);
      cyc(3);
      chk("r_no_early_dec", dig(0), 'h99);
      cyc(1);
      chk("r_d98", dig(0), 'h98);

      // 5b: start from DONE, START=01
      st[4] = 1'b1;
      cyc(1);
      st[4] = 1'b0;
      cyc(4);
      chk("d_done_digits", dig(4), 'h00);
      chk("d_done_timeout", int'(to_w[4]), 1);
      cyc(2);
      st[4] = 1'b1;
      cyc(1);
      st[4] = 1'b0;
      chk("d_reload", dig(4), 'h01);
      chk("d_running", int'(run_w[4]), 1);
      chk("d_no_timeout", int'(to_w[4]), 0);

      // zero start goes straight to DONE
      st[5] = 1'b1;
      cyc(1);
      st[5] = 1'b0;
      chk("z_timeout", int'(to_w[5]), 1);
      chk("z_running", int'(run_w[5]), 0);
      cyc(1);
      chk("z_timeout_clr", int'(to_w[5]), 0);

      // 6: async reset mid-count
      rs[0] = 1'b1;
      cyc(1);
      rs[0] = 1'b0;
      st[0] = 1'b1;
      cyc(1);
      st[0] = 1'b0;
      cyc(16);
      chk("a_d95", dig(0), 'h95);
      #2;
      rs[0] = 1'b1;
      #1;
      chk("a_digits", dig(0), 'h99);
      chk("a_running", int'(run_w[0]), 0);
      chk("a_timeout", int'(to_w[0]), 0);
      cyc(1);
      rs[0] = 1'b0;
      cyc(2);
      chk("a_idle_after", dig(0), 'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
